// File: rtl/seq_divider_32by16_pkg.sv
// Shared constants for the sequential 32/16 restoring divider:
// FSM state encodings and the quotient value reported on error.
package seq_divider_32by16_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [15:0] SAT_QUOTIENT = 16'hFFFF;

endpackage

// File: rtl/seq_divider_32by16_div_restoring_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, record the quotient bit.
module div_restoring_step #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] div,
  output logic [DATA_W-1:0] next_rem,
  output logic [DATA_W-1:0] next_quo
);

  logic [DATA_W:0] shifted;
  logic            fits;

  // The shifted remainder needs one extra bit so the compare cannot wrap.
  assign shifted  = {rem, quo[DATA_W-1]};
  assign fits     = shifted >= {1'b0, div};
  assign next_rem = fits ? (shifted[DATA_W-1:0] - div) : shifted[DATA_W-1:0];
  assign next_quo = {quo[DATA_W-2:0], fits};

endmodule

// File: rtl/seq_divider_32by16.sv
// Unsigned sequential restoring divider, 2*DATA_W / DATA_W, one quotient bit
// per clock behind a start/done handshake.
module seq_divider_32by16
  import seq_divider_32by16_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [2*DATA_W-1:0]   iDividend,
  input  logic [DATA_W-1:0]     iDivisor,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [DATA_W-1:0]     oQuotient,
  output logic [DATA_W-1:0]     oRemainder,
  output logic                  oOverflow,
  output logic                  oDivByZero
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] rem_reg;
  logic [DATA_W-1:0] quo_reg;
  logic [DATA_W-1:0] div_reg;
  logic [DATA_W-1:0] next_rem;
  logic [DATA_W-1:0] next_quo;
  logic [DATA_W-1:0] dividend_hi;

  assign dividend_hi = iDividend[2*DATA_W-1:DATA_W];

  div_restoring_step #(.DATA_W(DATA_W)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .div      (div_reg),
    .next_rem (next_rem),
    .next_quo (next_quo)
  );

  assign oBusy = (state == ST_CALC);
  assign oDone = (state == ST_DONE);

  // A start with a zero divisor or an upper half that already reaches the
  // divisor cannot produce a DATA_W-bit quotient, so it finishes immediately.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      div_reg    <= '0;
      oQuotient  <= '0;
      oRemainder <= '0;
      oOverflow  <= 1'b0;
      oDivByZero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (iStart) begin
            div_reg    <= iDivisor;
            rem_reg    <= dividend_hi;
            quo_reg    <= iDividend[DATA_W-1:0];
            count      <= '0;
            oQuotient  <= '0;
            oRemainder <= '0;
            oOverflow  <= 1'b0;
            oDivByZero <= 1'b0;
            if (iDivisor == '0) begin
              oDivByZero <= 1'b1;
              oQuotient  <= SAT_QUOTIENT;
              state      <= ST_DONE;
            end else if (dividend_hi >= iDivisor) begin
              oOverflow  <= 1'b1;
              oQuotient  <= SAT_QUOTIENT;
              state      <= ST_DONE;
            end else begin
              state      <= ST_CALC;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          rem_reg <= next_rem;
          quo_reg <= next_quo;
          count   <= count + 1'b1;
          if (count == LAST_ITER) begin
            state      <= ST_DONE;
            oQuotient  <= next_quo;
            oRemainder <= next_rem;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_32by16.sv
// Directed and product-based checks for seq_divider_32by16, including
// error paths, ignored restarts, mid-operation reset and back-to-back starts.
module tb_seq_divider_32by16;

  logic        Clock;
  logic        Reset;
  logic        iStart;
  logic [31:0] iDividend;
  logic [15:0] iDivisor;
  logic        oBusy;
  logic        oDone;
  logic [15:0] oQuotient;
  logic [15:0] oRemainder;
  logic        oOverflow;
  logic        oDivByZero;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        ovf;
    logic        dbz;
    int          latency;
  } vec_t;

  vec_t vecs[10];

  seq_divider_32by16 dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .iStart     (iStart),
    .iDividend  (iDividend),
    .iDivisor   (iDivisor),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oQuotient  (oQuotient),
    .oRemainder (oRemainder),
    .oOverflow  (oOverflow),
    .oDivByZero (oDivByZero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Waits at the next falling edge and presents a start request for one edge.
  task automatic applyStimulus(input logic [31:0] dividend, input logic [15:0] divisor);
    @(negedge Clock);
    iStart    = 1'b1;
    iDividend = dividend;
    iDivisor  = divisor;
  endtask

  // Latency is counted in falling edges after the acceptance edge; injectAt
  // optionally re-asserts iStart with other operands at that falling edge.
  task automatic waitDone(input int injectAt, input logic [31:0] injDividend, input logic [15:0] injDivisor,
                          output int latency, output int busy);
    latency = 0;
    busy    = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clock);
      if (c == injectAt) begin
        iStart    = 1'b1;
        iDividend = injDividend;
        iDivisor  = injDivisor;
      end else begin
        iStart = 1'b0;
      end
      if (oDone) begin
        latency = c;
        break;
      end
      if (oBusy) busy++;
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(oBusy), 32'd0);
    checkOutput({tag, "_done"}, 32'(oDone), 32'd0);
    checkOutput({tag, "_quotient"}, 32'(oQuotient), 32'd0);
    checkOutput({tag, "_remainder"}, 32'(oRemainder), 32'd0);
    checkOutput({tag, "_overflow"}, 32'(oOverflow), 32'd0);
    checkOutput({tag, "_divbyzero"}, 32'(oDivByZero), 32'd0);
  endtask

  initial begin
    int lat;
    int busy;
    int doneSeen;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;

    vecs[0] = '{32'h0001_86A0, 16'h0007, 16'h37CD, 16'h0005, 1'b0, 1'b0, 17};
    vecs[1] = '{32'hFFFE_0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17};
    vecs[2] = '{32'h0000_0000, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0, 17};
    vecs[3] = '{32'h0000_04D2, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1};
    vecs[4] = '{32'h0010_0000, 16'h0010, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1};
    vecs[5] = '{32'h0000_03E8, 16'h0003, 16'd333,  16'd1,    1'b0, 1'b0, 17};
    vecs[6] = '{32'h0000_FFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17};
    vecs[7] = '{32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1};
    vecs[8] = '{32'h0006_FFFF, 16'h0007, 16'hFFFF, 16'h0006, 1'b0, 1'b0, 17};
    vecs[9] = '{32'hFFFF_0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1};

    Reset     = 1'b1;
    iStart    = 1'b0;
    iDividend = '0;
    iDivisor  = '0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    checkIdleOutputs("reset");

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].dividend, vecs[i].divisor);
      waitDone(0, '0, '0, lat, busy);
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].latency));
      checkOutput($sformatf("v%0d_busy_cycles", i), 32'(busy), (vecs[i].latency == 17) ? 32'd16 : 32'd0);
      checkOutput($sformatf("v%0d_quotient", i), 32'(oQuotient), 32'(vecs[i].quotient));
      checkOutput($sformatf("v%0d_remainder", i), 32'(oRemainder), 32'(vecs[i].remainder));
      checkOutput($sformatf("v%0d_overflow", i), 32'(oOverflow), 32'(vecs[i].ovf));
      checkOutput($sformatf("v%0d_divbyzero", i), 32'(oDivByZero), 32'(vecs[i].dbz));
      @(negedge Clock);
      checkOutput($sformatf("v%0d_done_pulse", i), 32'(oDone), 32'd0);
      checkOutput($sformatf("v%0d_quotient_held", i), 32'(oQuotient), 32'(vecs[i].quotient));
    end

    $display("[TB] products with remainder");
    for (int i = 0; i < 500; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(1, 65535));
      c = (i % 2 == 0) ? 16'd0 : 16'($urandom_range(0, 32'(b) - 1));
      applyStimulus(32'(a) * 32'(b) + 32'(c), b);
      waitDone(0, '0, '0, lat, busy);
      checkOutput($sformatf("prod%0d_latency", i), 32'(lat), 32'd17);
      checkOutput($sformatf("prod%0d_quotient", i), 32'(oQuotient), 32'(a));
      checkOutput($sformatf("prod%0d_remainder", i), 32'(oRemainder), 32'(c));
      checkOutput($sformatf("prod%0d_flags", i), 32'({oOverflow, oDivByZero}), 32'd0);
    end

    $display("[TB] restart during CALC is ignored");
    applyStimulus(32'd1000, 16'd3);
    waitDone(5, 32'd50, 16'd7, lat, busy);
    checkOutput("ignore_latency", 32'(lat), 32'd17);
    checkOutput("ignore_quotient", 32'(oQuotient), 32'd333);
    checkOutput("ignore_remainder", 32'(oRemainder), 32'd1);

    $display("[TB] reset clears held results");
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    checkIdleOutputs("reset_held");

    $display("[TB] reset at iteration 8");
    applyStimulus(32'h0001_86A0, 16'h0007);
    waitDone(0, '0, '0, lat, busy);
    checkOutput("pre_reset_quotient", 32'(oQuotient), 32'h37CD);
    applyStimulus(32'd1000, 16'd3);
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clock);
      iStart = 1'b0;
    end
    checkOutput("midcalc_busy", 32'(oBusy), 32'd1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    checkIdleOutputs("reset_midcalc");
    doneSeen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clock);
      if (oDone || oBusy) doneSeen++;
    end
    checkOutput("reset_no_done", 32'(doneSeen), 32'd0);
    applyStimulus(32'd1000, 16'd3);
    waitDone(0, '0, '0, lat, busy);
    checkOutput("post_reset_latency", 32'(lat), 32'd17);
    checkOutput("post_reset_quotient", 32'(oQuotient), 32'd333);
    checkOutput("post_reset_remainder", 32'(oRemainder), 32'd1);

    $display("[TB] back-to-back start in DONE");
    applyStimulus(32'd100, 16'd9);
    waitDone(0, '0, '0, lat, busy);
    checkOutput("b2b_first_latency", 32'(lat), 32'd17);
    checkOutput("b2b_first_quotient", 32'(oQuotient), 32'd11);
    checkOutput("b2b_first_remainder", 32'(oRemainder), 32'd1);
    iStart    = 1'b1;
    iDividend = 32'd50;
    iDivisor  = 16'd7;
    waitDone(0, '0, '0, lat, busy);
    checkOutput("b2b_second_latency", 32'(lat), 32'd17);
    checkOutput("b2b_second_busy_cycles", 32'(busy), 32'd16);
    checkOutput("b2b_second_quotient", 32'(oQuotient), 32'd7);
    checkOutput("b2b_second_remainder", 32'(oRemainder), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
